// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned REG_ZERO   = 0;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_MDU
    } gnt_src_e;

endpackage

// File: rtl/wb_result_fifo.sv
// MDU result buffer: circular FIFO with a youngest-match lookup over the live entries.
module wb_result_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter  int unsigned DATA_W = DATA_W_DEF,
    parameter  int unsigned ADDR_W = ADDR_W_DEF,
    parameter  int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [ADDR_W-1:0] i_push_addr,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [ADDR_W-1:0] o_head_addr,
    output logic [DATA_W-1:0] o_head_data,
    output logic              o_empty,
    output logic              o_full,
    output logic [CNT_W-1:0]  o_count,
    input  logic [ADDR_W-1:0] i_lookup_addr,
    output logic              o_hit,
    output logic [DATA_W-1:0] o_hit_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == CNT_W'(DEPTH));
    assign o_count     = r_count;
    assign o_head_addr = r_addr[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign w_do_push   = i_push & ~o_full;
    assign w_do_pop    = i_pop & ~o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_addr[r_wr_ptr] <= i_push_addr;
                r_data[r_wr_ptr] <= i_push_data;
                r_wr_ptr         <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        o_hit      = 1'b0;
        o_hit_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < r_count) &&
                (r_addr[r_rd_ptr + PTR_W'(i)] == i_lookup_addr) &&
                (i_lookup_addr != ADDR_W'(REG_ZERO))) begin
                o_hit      = 1'b1;
                o_hit_data = r_data[r_rd_ptr + PTR_W'(i)];
            end
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between pipeline writeback and buffered MDU results,
// stalling the pipeline briefly when a buffered result has waited too long.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter  int unsigned DATA_W       = DATA_W_DEF,
    parameter  int unsigned ADDR_W       = ADDR_W_DEF,
    parameter  int unsigned FIFO_DEPTH   = 4,
    parameter  int unsigned STARVE_LIMIT = 3,
    localparam int unsigned CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_pipe_we,
    input  logic [ADDR_W-1:0] i_pipe_waddr,
    input  logic [DATA_W-1:0] i_pipe_wdata,
    input  logic              i_mdu_valid,
    input  logic [ADDR_W-1:0] i_mdu_waddr,
    input  logic [DATA_W-1:0] i_mdu_wdata,
    output logic              o_mdu_ready,
    output logic              o_rf_we,
    output logic [ADDR_W-1:0] o_rf_waddr,
    output logic [DATA_W-1:0] o_rf_wdata,
    output logic              o_pipe_stall,
    input  logic [ADDR_W-1:0] i_fwd_raddr,
    output logic              o_fwd_hit,
    output logic [DATA_W-1:0] o_fwd_data,
    output logic [CNT_W-1:0]  o_fifo_count
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic              r_rf_we;
    logic [ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_pipe_stall;
    logic [SW-1:0]     r_starve;

    gnt_src_e          w_gnt;
    logic              w_push;
    logic              w_pop;
    logic              w_fifo_empty;
    logic              w_fifo_full;
    logic [ADDR_W-1:0] w_head_addr;
    logic [DATA_W-1:0] w_head_data;

    assign o_mdu_ready  = ~w_fifo_full;
    // Address-0 results complete the handshake but are dropped.
    assign w_push       = i_mdu_valid & ~w_fifo_full & (i_mdu_waddr != ADDR_W'(REG_ZERO));
    assign w_pop        = (w_gnt == GNT_MDU);
    assign o_rf_we      = r_rf_we;
    assign o_rf_waddr   = r_rf_waddr;
    assign o_rf_wdata   = r_rf_wdata;
    assign o_pipe_stall = r_pipe_stall;

    always_comb begin
        w_gnt = GNT_NONE;
        if (r_pipe_stall && !w_fifo_empty) begin
            w_gnt = GNT_MDU;
        end else if (i_pipe_we && (i_pipe_waddr != ADDR_W'(REG_ZERO))) begin
            w_gnt = GNT_PIPE;
        end else if (!w_fifo_empty) begin
            w_gnt = GNT_MDU;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_rf_wdata   <= '0;
            r_pipe_stall <= 1'b0;
            r_starve     <= '0;
        end else begin
            r_rf_we <= (w_gnt != GNT_NONE);
            case (w_gnt)
                GNT_PIPE: begin
                    r_rf_waddr <= i_pipe_waddr;
                    r_rf_wdata <= i_pipe_wdata;
                end
                GNT_MDU: begin
                    r_rf_waddr <= w_head_addr;
                    r_rf_wdata <= w_head_data;
                end
                default: ;
            endcase
            if (w_fifo_empty || w_pop) begin
                r_starve <= '0;
            end else if (r_starve != SW'(STARVE_LIMIT)) begin
                r_starve <= r_starve + 1'b1;
            end
            // Fires once: the following cycle pops the head and clears the counter.
            r_pipe_stall <= (r_starve == SW'(STARVE_LIMIT - 1)) && !w_pop && !w_fifo_empty;
        end
    end

    wb_result_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_push        (w_push),
        .i_push_addr   (i_mdu_waddr),
        .i_push_data   (i_mdu_wdata),
        .i_pop         (w_pop),
        .o_head_addr   (w_head_addr),
        .o_head_data   (w_head_data),
        .o_empty       (w_fifo_empty),
        .o_full        (w_fifo_full),
        .o_count       (o_fifo_count),
        .i_lookup_addr (i_fwd_raddr),
        .o_hit         (o_fwd_hit),
        .o_hit_data    (o_fwd_data)
    );

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a queue-based reference model predicts register-file
// writes; a separate monitor pops and compares each observed write.
module tb_wb_port_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pipe_we = 1'b0;
    logic [4:0]  pipe_waddr = '0;
    logic [31:0] pipe_wdata = '0;
    logic        mdu_valid = 1'b0;
    logic [4:0]  mdu_waddr = '0;
    logic [31:0] mdu_wdata = '0;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        pipe_stall;
    logic [4:0]  fwd_raddr = '0;
    logic        fwd_hit;
    logic [31:0] fwd_data;
    logic [2:0]  fifo_count;

    wb_port_arbiter #(
        .DATA_W       (32),
        .ADDR_W       (5),
        .FIFO_DEPTH   (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_pipe_we    (pipe_we),
        .i_pipe_waddr (pipe_waddr),
        .i_pipe_wdata (pipe_wdata),
        .i_mdu_valid  (mdu_valid),
        .i_mdu_waddr  (mdu_waddr),
        .i_mdu_wdata  (mdu_wdata),
        .o_mdu_ready  (mdu_ready),
        .o_rf_we      (rf_we),
        .o_rf_waddr   (rf_waddr),
        .o_rf_wdata   (rf_wdata),
        .o_pipe_stall (pipe_stall),
        .i_fwd_raddr  (fwd_raddr),
        .o_fwd_hit    (fwd_hit),
        .o_fwd_data   (fwd_data),
        .o_fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: what the DUT should show after the most recent edge.
    wr_t         mq[$];
    wr_t         exp_q[$];
    int          m_wait = 0;
    bit          m_stall = 0;
    bit          m_we = 0;
    logic [4:0]  m_addr = '0;
    logic [31:0] m_data = '0;
    bit          m_acc = 0;

    // Stimulus for the next step.
    logic        s_pw, s_mv, s_rst;
    logic [4:0]  s_pa, s_ma, s_fa;
    logic [31:0] s_pd, s_md;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every observed write must match the oldest predicted write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL wr_unexpected: got r%0d=%0h expected no write at %0t",
                         rf_waddr, rf_wdata, $time);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                chk("wr_addr", 64'(rf_waddr), 64'(w.addr));
                chk("wr_data", 64'(rf_wdata), 64'(w.data));
            end
        end
    end

    task automatic step();
        bit          nonempty, pop, accept, hit, nstall;
        logic [31:0] fd;
        wr_t         w;
        @(negedge clk);
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_waddr_hold", 64'(rf_waddr), 64'(m_addr));
        chk("rf_wdata_hold", 64'(rf_wdata), 64'(m_data));
        chk("pipe_stall", 64'(pipe_stall), 64'(m_stall));
        chk("mdu_ready", 64'(mdu_ready), 64'(mq.size() < DEPTH));
        chk("fifo_count", 64'(fifo_count), 64'(mq.size()));
        rst        = s_rst;
        pipe_we    = s_pw;
        pipe_waddr = s_pa;
        pipe_wdata = s_pd;
        mdu_valid  = s_mv;
        mdu_waddr  = s_ma;
        mdu_wdata  = s_md;
        fwd_raddr  = s_fa;
        #1;
        hit = 0;
        fd  = '0;
        for (int i = 0; i < mq.size(); i++) begin
            if (s_fa != 0 && mq[i].addr == s_fa) begin
                hit = 1;
                fd  = mq[i].data;
            end
        end
        chk("fwd_hit", 64'(fwd_hit), 64'(hit));
        chk("fwd_data", 64'(fwd_data), 64'(fd));
        if (s_rst) begin
            mq.delete();
            m_wait  = 0;
            m_stall = 0;
            m_we    = 0;
            m_addr  = '0;
            m_data  = '0;
            m_acc   = 0;
            return;
        end
        nonempty = (mq.size() > 0);
        accept   = s_mv && (mq.size() < DEPTH);
        pop      = 0;
        m_we     = 1;
        w        = '0;
        if (m_stall && nonempty) pop = 1;
        else if (s_pw && s_pa != 0) w = '{addr: s_pa, data: s_pd};
        else if (nonempty) pop = 1;
        else m_we = 0;
        if (pop) w = mq.pop_front();
        if (accept && s_ma != 0) mq.push_back('{addr: s_ma, data: s_md});
        m_acc = accept;
        if (m_we) begin
            m_addr = w.addr;
            m_data = w.data;
            exp_q.push_back(w);
        end
        nstall = (m_wait == LIMIT - 1) && !pop && nonempty;
        if (!nonempty || pop) m_wait = 0;
        else if (m_wait < LIMIT) m_wait++;
        m_stall = nstall;
    endtask

    task automatic idle_in();
        s_rst = 0; s_pw = 0; s_pa = '0; s_pd = '0;
        s_mv = 0; s_ma = '0; s_md = '0; s_fa = '0;
    endtask

    // Next pipe write unless the WB stage is frozen; next MDU result once the last was taken.
    task automatic traffic_in(input logic [4:0] pa, input logic [31:0] pd,
                              input bit new_mdu, input logic [4:0] ma, input logic [31:0] md);
        if (!m_stall) begin
            s_pw = 1; s_pa = pa; s_pd = pd;
        end
        if (!s_mv || m_acc) begin
            s_mv = new_mdu; s_ma = ma; s_md = md;
        end
    endtask

    initial begin
        int stalls;
        int pushed;
        idle_in();
        repeat (2) @(posedge clk);

        // Reset then idle.
        repeat (2) step();

        // Pipe-only: r5 write, then address 0 is no request.
        s_pw = 1; s_pa = 5'd5; s_pd = 32'hDEADBEEF;
        step();
        s_pa = 5'd0; s_pd = 32'h11111111;
        step();
        idle_in();
        step();

        // MDU into an idle port, with a forwarding probe while buffered.
        s_mv = 1; s_ma = 5'd8; s_md = 32'h12345678;
        step();
        idle_in();
        s_fa = 5'd8;
        step();
        s_fa = 5'd0;
        repeat (2) step();

        // Starvation: one MDU entry against continuous pipe writes.
        s_mv = 1; s_ma = 5'd3; s_md = 32'hAAAA0003;
        s_pw = 1; s_pa = 5'd10; s_pd = 32'h100;
        step();
        s_mv = 0;
        stalls = 0;
        for (int i = 0; i < 10; i++) begin
            traffic_in(5'(11 + i), 32'(32'h200 + i), 0, '0, '0);
            step();
            if (pipe_stall === 1'b1) stalls++;
        end
        chk("stall_pulses", 64'(stalls), 64'd1);
        idle_in();
        repeat (3) step();

        // Full FIFO under continuous pipe traffic; MDU valid held until taken.
        pushed = 0;
        for (int i = 0; i < 30; i++) begin
            if (m_acc && s_mv) pushed++;
            traffic_in(5'(1 + (i % 30)), $urandom, pushed < 6, 5'(20 + pushed),
                       32'(32'hC000 + pushed));
            step();
        end
        idle_in();
        repeat (8) step();

        // Reset mid-drain with three entries buffered.
        for (int i = 0; i < 3; i++) begin
            s_pw = 1; s_pa = 5'(12 + i); s_pd = $urandom;
            s_mv = 1; s_ma = 5'(25 + i); s_md = $urandom;
            step();
        end
        idle_in();
        s_rst = 1;
        step();
        s_rst = 0;
        for (int i = 0; i < 3; i++) begin
            s_fa = 5'(25 + i);
            step();
        end

        // Randomized traffic with occasional resets.
        idle_in();
        for (int n = 0; n < 3000; n++) begin
            if (!m_stall) begin
                s_pw = ($urandom % 4) != 0;
                s_pa = 5'($urandom);
                s_pd = $urandom;
            end
            if (!s_mv || m_acc || s_rst) begin
                s_mv = ($urandom % 3) == 0;
                s_ma = 5'($urandom);
                s_md = $urandom;
            end
            if (mq.size() > 0 && ($urandom % 2) == 0) s_fa = mq[$urandom % mq.size()].addr;
            else s_fa = 5'($urandom);
            s_rst = ($urandom % 200) == 0;
            step();
        end
        idle_in();
        repeat (12) step();
        @(negedge clk);
        chk("pending_writes", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two sources: the in-order pipeline writeback and results returned by a long-latency multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO and drained when the pipeline is not using the port.
- A starvation counter briefly stalls the pipeline so that buffered results always drain.
- Provides forwarding lookups into the buffered results.
- Sits between the writeback stage and the register file.

Parameters:
- DATA_W, 32: register data width
- ADDR_W, 5: register index width
- FIFO_DEPTH, 4: MDU result buffer entries (power of two, >=2)
- STARVE_LIMIT, 3: cycles the FIFO head may wait before the pipeline is stalled

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pipe_we  in  1  pipeline writeback request (regwrite flag)
- pipe_waddr  in  ADDR_W  pipeline destination register
- pipe_wdata  in  DATA_W  pipeline result (mem or ALU, already selected)
- mdu_valid  in  1  MDU result valid
- mdu_waddr  in  ADDR_W  MDU destination register
- mdu_wdata  in  DATA_W  MDU result
- mdu_ready  out  1  FIFO can accept; transfer occurs when mdu_valid & mdu_ready
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  ADDR_W  register-file write address (registered)
- rf_wdata  out  DATA_W  register-file write data (registered)
- pipe_stall  out  1  freeze pipeline WB stage this cycle (registered)
- fwd_raddr  in  ADDR_W  forwarding query address
- fwd_hit  out  1  query matches a buffered entry (combinational)
- fwd_data  out  DATA_W  data of the youngest matching entry (combinational)
- fifo_count  out  clog2(FIFO_DEPTH)+1  buffered entries

Behaviour:
- Reset (synchronous, clk edge with rst=1):
  - rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0.
  - FIFO emptied, pointers=0, starvation counter=0, fifo_count=0.
  - Reset mid-operation discards all buffered MDU results.
- Register index 0 is never written:
  - pipe_we with pipe_waddr=0 is treated as no request.
  - MDU results with addr 0 are accepted (handshake completes) but not enqueued.
- mdu_ready = (fifo_count < FIFO_DEPTH), from current state only.
  - A pop in the same cycle does not make room for a push in that cycle.
- Grant decision each cycle, evaluated on current inputs and state:
  - If pipe_stall=1 and FIFO non-empty: grant FIFO head. The pipeline holds its WB request unchanged; that request is written after the stall.
  - Else if pipe_we & pipe_waddr!=0: grant pipeline.
  - Else if FIFO non-empty: grant FIFO head.
  - Else: no grant.
- Output timing: the granted address/data appear on rf_* at the next clk edge with rf_we=1, giving 1-cycle latency. With no grant, rf_we=0 and rf_waddr/rf_wdata hold their values.
- FIFO behaviour:
  - Push at tail and pop of head may occur in the same cycle.
  - An entry pushed in cycle N is eligible for grant no earlier than cycle N+1.
  - Pointers wrap modulo FIFO_DEPTH.
- Starvation counter:
  - Cleared when the FIFO is empty or the head is popped.
  - Otherwise increments, saturating at STARVE_LIMIT.
  - pipe_stall is registered as (counter==STARVE_LIMIT-1 & head not popped & FIFO non-empty). It is therefore high for exactly one cycle, during which the head is popped.
- Forwarding:
  - fwd_hit=1 if any valid entry has addr==fwd_raddr and fwd_raddr!=0.
  - fwd_data = data of the youngest such entry, otherwise 0.
  - The entry currently being popped still counts until the edge.
- Ordering: MDU entries drain in FIFO order. WAW hazards between the pipeline and pending MDU destinations are prevented by the hazard unit; the block does not reorder or squash.

Decomposition:
- Shared package: DATA_W/ADDR_W defaults, REG_ZERO constant, grant-source enum (GNT_NONE, GNT_PIPE, GNT_MDU).
- One sub-module: wb_result_fifo. It holds the storage array, pointers, count, push/pop, and the youngest-match CAM lookup.
- The arbiter, starvation counter and output registers stay in the top.

Test Plan:
- Reset then idle: check rf_we=0, rf_waddr=0, rf_wdata=0, pipe_stall=0, mdu_ready=1, fifo_count=0.
- Pipe-only traffic: pipe_we=1, addr=5, data=0xDEADBEEF at cycle N -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at N+1. Then addr=0 -> rf_we=0.
- MDU into idle port: push (addr 8, 0x12345678) at N -> fifo_count=1 at N+1 and rf write of r8=0x12345678 visible at N+2; fwd_raddr=8 gives hit=1, data=0x12345678 during N+1.
- Starvation: one MDU entry plus continuous pipe writes with STARVE_LIMIT=3 -> pipe_stall=1 for exactly one cycle. The MDU entry is written that cycle and the held pipe write is written the cycle after, with no write lost.
- Full FIFO: push 4 entries under continuous pipe traffic -> mdu_ready=0. A mdu_valid held high is not accepted until a pop occurs, then accepted the following cycle. Entries drain in order.
- Reset mid-drain with 3 entries buffered -> next cycle fifo_count=0, rf_we=0, pipe_stall=0, fwd_hit=0 for all previously buffered addresses.
